approx_err_monitor: RTL and testbench
=====================================

# approx_err_monitor

Error-metric accumulator that sits directly downstream of the hybrid approximate adders (LOA-family, N-bit operands, N+1-bit sum).
- Samples each operand pair together with the approximate adder's SUM and recomputes the exact sum internally.
- Accumulates error distance (ED) statistics over a window of 2^W accepted samples: ED sum, maximum ED and the count of erroneous samples.
- Results feed the characterisation flow that derives MED/ER figures for each N/P configuration.

## Interface
Parameters:
- N, 16, operand width; must match the approximate adder feeding the block
- W, 10, log2 of samples per window (window = 2^W samples)

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  single-cycle pulse that opens a new measurement window
- in_valid  input  1  X/Y/SUM hold a valid sample this cycle
- X  input  N  operand A, as presented to the approximate adder
- Y  input  N  operand B, as presented to the approximate adder
- SUM  input  N+1  approximate adder output for X, Y
- busy  output  1  high in RUN and DRAIN
- done  output  1  high while results are valid (DONE state)
- ed_sum  output  N+1+W  sum of |exact − SUM| over the window
- ed_max  output  N+1  largest single ED in the window
- err_count  output  W+1  number of samples with ED ≠ 0

## Operation
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start → clear accumulators and sample counter, go to RUN.
  - All other inputs ignored.
- RUN:
  - A sample is accepted on every cycle with in_valid = 1; the sample counter increments.
  - The accepting edge of sample 2^W moves the FSM to DRAIN.
  - start is ignored. in_valid gaps are allowed and do not count.
- DRAIN:
  - in_valid is ignored.
  - Go to DONE once both pipeline valid bits are 0.
- DONE:
  - done = 1; outputs hold.
  - start → clear accumulators, go to RUN. done falls on the same edge.
- Pipeline:
  - Stage 1 registers exact = X + Y (N+1 bits, zero-extended) and SUM, with valid.
  - Stage 2 registers ED = |exact − SUM| (N+1 bits, unsigned magnitude; SUM may exceed exact), with valid.
  - Accumulate on stage-2 valid:
    - ed_sum += ED
    - ed_max = max(ed_max, ED)
    - err_count += (ED ≠ 0)
- Widths are sized so no overflow is possible: worst case (2^(N+1)−1)·2^W fits in N+1+W bits. No saturation logic.
- start and in_valid high in the same cycle from IDLE/DONE: only start acts; that sample is not accepted.
- Sample counter is W+1 bits and never wraps within a window.

## Timing
- Reset, on any state including mid-window:
  - FSM → IDLE.
  - busy = 0, done = 0.
  - ed_sum, ed_max and err_count = 0.
  - Pipeline valids and sample counter = 0.
  - Any in-flight samples are discarded.
- busy rises on the edge after start is sampled.
- The first sample can be accepted in the cycle after start.
- Latency from a sample's accepting edge k:
  - ED registered at k+1.
  - Accumulated at k+2.
- done rises at edge k+3, where k is the accepting edge of the final (2^W-th) sample. busy falls on that same edge.
- No backpressure: the block accepts one sample per cycle indefinitely in RUN.
- Outputs are registered and remain stable throughout DONE.

## Test plan
- Reset/idle: assert rst 2 cycles, then toggle in_valid with no start → busy = 0, done = 0, all results 0 throughout.
- Exact window (W=2, N=16): start, then 4 back-to-back samples with SUM = X+Y (e.g. 100+27 → 127) → done exactly 3 edges after the 4th accept; ed_sum = 0, ed_max = 0, err_count = 0.
- Mixed errors (W=2): X=100, Y=27 with SUM = 127, 120, 130, 115 (EDs 0, 7, 3, 12) → ed_sum = 22, ed_max = 12, err_count = 3.
- Gaps and ignored inputs (W=2): in_valid pattern 1,0,0,1,0,1,1, plus a start pulse mid-RUN and in_valid during DRAIN → only 4 samples counted; start has no effect; results match the 4 counted samples.
- Width worst case (W=2, N=16): X=Y=0, SUM=17'h1FFFF ×4 → ed_sum = 524284, ed_max = 131071, err_count = 4, no overflow.
- Reset mid-window and restart: rst after 2 of 4 samples → all outputs 0, IDLE. A fresh start plus 4 samples gives correct results. A start issued in DONE clears results and drops done on the next edge.

Source files
------------

// File: rtl/approx_err_monitor_if.sv
// Sample/result bundle between the approximate-adder harness and approx_err_monitor.
// X, Y and SUM keep the adder's own port names so traces line up with the adder.
interface approx_err_monitor_if #(
  parameter int N = 16,
  parameter int W = 10
);
  logic             start;
  logic             in_valid;
  logic [N-1:0]     X;
  logic [N-1:0]     Y;
  logic [N:0]       SUM;
  logic             busy;
  logic             done;
  logic [N+W:0]     ed_sum;
  logic [N:0]       ed_max;
  logic [W:0]       err_count;

  modport master (
    output start, in_valid, X, Y, SUM,
    input  busy, done, ed_sum, ed_max, err_count
  );

  modport slave (
    input  start, in_valid, X, Y, SUM,
    output busy, done, ed_sum, ed_max, err_count
  );
endinterface

// File: rtl/approx_err_monitor.sv
// Error-distance accumulator over a 2^W-sample window for approximate adders.
// Two-stage pipeline: exact sum, then |exact - SUM|, then accumulate.
module approx_err_monitor #(
  parameter int N = 16,
  parameter int W = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  approx_err_monitor_if.slave  bus
);
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [W:0] CNT_LAST = {1'b0, {W{1'b1}}};
  localparam logic [W:0] CNT_ONE  = {{W{1'b0}}, 1'b1};

  logic [1:0]   state_q, state_d;
  logic [W:0]   cnt_q, cnt_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         s1_valid_q, s1_valid_d;
  logic [N:0]   s1_exact_q, s1_exact_d;
  logic [N:0]   s1_sum_q, s1_sum_d;
  logic         s2_valid_q, s2_valid_d;
  logic [N:0]   s2_ed_q, s2_ed_d;
  logic [N+W:0] ed_sum_q, ed_sum_d;
  logic [N:0]   ed_max_q, ed_max_d;
  logic [W:0]   err_count_q, err_count_d;
  logic         accept;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ed_sum_d    = ed_sum_q;
    ed_max_d    = ed_max_q;
    err_count_d = err_count_q;
    accept      = 1'b0;

    if (s2_valid_q) begin
      ed_sum_d    = ed_sum_q + {{W{1'b0}}, s2_ed_q};
      ed_max_d    = (s2_ed_q > ed_max_q) ? s2_ed_q : ed_max_q;
      err_count_d = err_count_q + {{W{1'b0}}, (s2_ed_q != '0)};
    end

    // The window-open clear is placed after accumulation so it wins; the pipeline
    // is always empty in IDLE/DONE, so nothing is lost.
    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d     = RUN;
          cnt_d       = '0;
          ed_sum_d    = '0;
          ed_max_d    = '0;
          err_count_d = '0;
        end
      end
      RUN: begin
        if (bus.in_valid) begin
          accept = 1'b1;
          cnt_d  = cnt_q + CNT_ONE;
          if (cnt_q == CNT_LAST) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !s2_valid_q) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == DONE);
  end

  always_comb begin
    s1_valid_d = accept;
    s1_exact_d = accept ? ({1'b0, bus.X} + {1'b0, bus.Y}) : s1_exact_q;
    s1_sum_d   = accept ? bus.SUM : s1_sum_q;
    s2_valid_d = s1_valid_q;
    s2_ed_d    = s2_ed_q;
    if (s1_valid_q) begin
      s2_ed_d = (s1_exact_q >= s1_sum_q) ? (s1_exact_q - s1_sum_q)
                                         : (s1_sum_q - s1_exact_q);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_exact_q  <= '0;
      s1_sum_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_ed_q     <= '0;
      ed_sum_q    <= '0;
      ed_max_q    <= '0;
      err_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      s1_valid_q  <= s1_valid_d;
      s1_exact_q  <= s1_exact_d;
      s1_sum_q    <= s1_sum_d;
      s2_valid_q  <= s2_valid_d;
      s2_ed_q     <= s2_ed_d;
      ed_sum_q    <= ed_sum_d;
      ed_max_q    <= ed_max_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.ed_sum    = ed_sum_q;
  assign bus.ed_max    = ed_max_q;
  assign bus.err_count = err_count_q;
endmodule

// File: tb/tb_approx_err_monitor.sv
// Directed bench for approx_err_monitor (N=16, W=2): expected EDs are queued per
// counted sample and reduced into window results when done is seen.
module tb_approx_err_monitor;
  localparam int N = 16;
  localparam int W = 2;
  localparam int WIN = 1 << W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   last_acc = 0;
  int   checks = 0;
  int   passes = 0;
  int   sb[$];

  approx_err_monitor_if #(.N(N), .W(W)) bus ();

  approx_err_monitor #(.N(N), .W(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int ed_of(input int x, input int y, input int s);
    int e;
    e = x + y;
    return (e >= s) ? (e - s) : (s - e);
  endfunction

  task automatic send(input int x, input int y, input int s, input bit counted);
    bus.in_valid = 1'b1;
    bus.X = x[N-1:0];
    bus.Y = y[N-1:0];
    bus.SUM = s[N:0];
    if (counted) sb.push_back(ed_of(x, y, s));
    step();
    if (counted) last_acc = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_res"}, {bus.ed_sum, bus.ed_max, bus.err_count}, 0);
  endtask

  task automatic wait_done_and_score(input string tag);
    int n;
    longint e_sum;
    int e_max, e_cnt, e_n, ed;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.done && n < 20);
    check({tag, "_done"}, bus.done, 1);
    check({tag, "_latency"}, cyc - last_acc, 3);
    check({tag, "_busy_low"}, bus.busy, 0);
    e_sum = 0; e_max = 0; e_cnt = 0; e_n = 0;
    while (sb.size() > 0) begin
      ed = sb.pop_front();
      e_sum += ed;
      if (ed > e_max) e_max = ed;
      if (ed != 0) e_cnt++;
      e_n++;
    end
    check({tag, "_nsamples"}, e_n, WIN);
    check({tag, "_ed_sum"}, bus.ed_sum, e_sum);
    check({tag, "_ed_max"}, bus.ed_max, e_max);
    check({tag, "_err_count"}, bus.err_count, e_cnt);
  endtask

  initial begin
    logic [63:0] held;
    int x, y, s;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.X = '0;
    bus.Y = '0;
    bus.SUM = '0;

    // reset and idle with stray in_valid
    step();
    step();
    rst = 1'b0;
    check_idle_zero("reset");
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = i[0];
      bus.X = 16'd5; bus.Y = 16'd9; bus.SUM = 17'd3;
      step();
      check({"idle_ignore_", $sformatf("%0d", i)}, {bus.busy, bus.done, bus.ed_sum, bus.ed_max, bus.err_count}, 0);
    end
    bus.in_valid = 1'b0;

    // exact window
    pulse_start();
    check("exact_busy_rise", bus.busy, 1);
    send(100, 27, 127, 1);
    send(1000, 2000, 3000, 1);
    send(65535, 65535, 131070, 1);
    send(0, 0, 0, 1);
    wait_done_and_score("exact");
    check("exact_zero_sum", bus.ed_sum, 0);
    held = {bus.ed_sum, bus.ed_max, bus.err_count};
    repeat (3) step();
    check("done_hold", bus.done, 1);
    check("done_hold_res", {bus.ed_sum, bus.ed_max, bus.err_count}, held);

    // mixed errors; start from DONE also checks the clear
    pulse_start();
    check("restart_done_fall", bus.done, 0);
    check("restart_busy", bus.busy, 1);
    check("restart_clear", {bus.ed_sum, bus.ed_max, bus.err_count}, 0);
    send(100, 27, 127, 1);
    send(100, 27, 120, 1);
    send(100, 27, 130, 1);
    send(100, 27, 115, 1);
    wait_done_and_score("mixed");
    check("mixed_const_sum", bus.ed_sum, 22);
    check("mixed_const_max", bus.ed_max, 12);
    check("mixed_const_cnt", bus.err_count, 3);

    // gaps, mid-RUN start, in_valid during DRAIN
    pulse_start();
    send(10, 20, 25, 1);
    step();
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    send(300, 400, 709, 1);
    step();
    send(7, 8, 15, 1);
    send(50, 50, 64, 1);
    bus.in_valid = 1'b1;
    bus.X = 16'd1; bus.Y = 16'd1; bus.SUM = 17'd1000;
    step();
    step();
    bus.in_valid = 1'b0;
    wait_done_and_score("gaps");

    // width worst case
    pulse_start();
    repeat (4) send(0, 0, 17'h1FFFF, 1);
    wait_done_and_score("worst");
    check("worst_const_sum", bus.ed_sum, 524284);
    check("worst_const_max", bus.ed_max, 131071);

    // reset mid-window, then a fresh window
    pulse_start();
    send(100, 27, 120, 1);
    send(100, 27, 130, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    sb.delete();
    check_idle_zero("midrst");
    repeat (4) step();
    check_idle_zero("midrst_settle");
    pulse_start();
    for (int i = 0; i < WIN; i++) begin
      x = $urandom_range(0, 65535);
      y = $urandom_range(0, 65535);
      s = x + y + $urandom_range(0, 40) - 20;
      if (s < 0) s = 0;
      if (s > 131071) s = 131071;
      send(x, y, s, 1);
    end
    wait_done_and_score("fresh");
    pulse_start();
    check("final_done_fall", bus.done, 0);
    check("final_clear", {bus.ed_sum, bus.ed_max, bus.err_count}, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
